// File: rtl/inst_rom_resp_pkg.sv
// Shared definitions for the instruction-memory responder: bus widths, chip-enable
// encodings, the NOP word, array size and FSM state encoding.
package inst_rom_resp_pkg;

   localparam int unsigned InstAddrBusW  = 32;
   localparam int unsigned InstBusW      = 32;
   localparam int unsigned InstMemNumLog2 = 10;

   localparam logic ChipEnable  = 1'b1;
   localparam logic ChipDisable = 1'b0;

   localparam logic [InstBusW-1:0] NopInst = 32'h0000_0000;

   typedef enum logic {
      StInit = 1'b0,
      StRun  = 1'b1
   } rom_state_e;

endpackage

// File: rtl/inst_ram_sdp.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// A same-address read and write in one cycle returns the old contents.
module inst_ram_sdp #(
   parameter int unsigned AddrW = 10,
   parameter int unsigned DataW = 32
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [DataW-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [DataW-1:0] rdata_o
);

   logic [DataW-1:0] mem_q [2**AddrW];
   logic [DataW-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_rom_resp.sv
// Instruction-memory responder: clears its array after reset, then serves one fetch per
// cycle with one cycle of latency, flagging misaligned and out-of-range addresses.
module inst_rom_resp
   import inst_rom_resp_pkg::*;
#(
   parameter int unsigned          DepthLog2 = InstMemNumLog2,
   parameter logic [InstBusW-1:0]  NopWord   = NopInst
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    ce_i,
   input  logic [InstAddrBusW-1:0] pc_i,
   output logic [InstBusW-1:0]     inst_o,
   output logic                    inst_valid_o,
   output logic                    inst_err_o,
   output logic                    ready_o,
   input  logic                    load_we_i,
   input  logic [DepthLog2-1:0]    load_addr_i,
   input  logic [InstBusW-1:0]     load_data_i
);

   rom_state_e           state_q, state_d;
   logic [DepthLog2-1:0] cnt_q, cnt_d;
   logic                 valid_q, valid_d;
   logic                 err_q, err_d;

   logic                 ram_we;
   logic [DepthLog2-1:0] ram_waddr;
   logic [InstBusW-1:0]  ram_wdata;
   logic                 ram_re;
   logic [InstBusW-1:0]  ram_rdata;

   logic                 req;
   logic                 misaligned;
   logic                 out_of_range;

   assign misaligned   = (pc_i[1:0] != 2'b00);
   assign out_of_range = ((pc_i >> (DepthLog2 + 2)) != '0);
   assign req          = (state_q == StRun) && (ce_i == ChipEnable);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ram_we    = 1'b0;
      ram_waddr = load_addr_i;
      ram_wdata = load_data_i;
      unique case (state_q)
         StInit: begin
            // Sweep owns the write port; the load port is ignored until the clear finishes.
            ram_we    = 1'b1;
            ram_waddr = cnt_q;
            ram_wdata = '0;
            cnt_d     = cnt_q + DepthLog2'(1);
            if (cnt_q == '1) begin
               state_d = StRun;
            end
         end
         StRun: begin
            ram_we = load_we_i;
         end
         default: state_d = StInit;
      endcase
   end

   always_comb begin
      valid_d = req;
      err_d   = req && (misaligned || out_of_range);
      ram_re  = req && !misaligned && !out_of_range;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StInit;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   inst_ram_sdp #(
      .AddrW (DepthLog2),
      .DataW (InstBusW)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .re_i    (ram_re),
      .raddr_i (pc_i[DepthLog2+1:2]),
      .rdata_o (ram_rdata)
   );

   // RAM output register has no reset, so it is only exposed behind a clean valid.
   assign inst_o       = (valid_q && !err_q) ? ram_rdata : NopWord;
   assign inst_valid_o = valid_q;
   assign inst_err_o   = err_q;
   assign ready_o      = (state_q == StRun);

endmodule

// File: tb/tb_inst_rom_resp.sv
// Directed self-checking bench for inst_rom_resp: init sweep, loads, fetch stream,
// error qualification, read-before-write collision and mid-run reset.
module tb_inst_rom_resp;

   logic        clk;
   logic        rst_n;
   logic        ce;
   logic [31:0] pc;
   logic [31:0] inst;
   logic        inst_valid;
   logic        inst_err;
   logic        ready;
   logic        load_we;
   logic [9:0]  load_addr;
   logic [31:0] load_data;

   int n_checks = 0;
   int n_errs   = 0;

   inst_rom_resp u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .ce_i         (ce),
      .pc_i         (pc),
      .inst_o       (inst),
      .inst_valid_o (inst_valid),
      .inst_err_o   (inst_err),
      .ready_o      (ready),
      .load_we_i    (load_we),
      .load_addr_i  (load_addr),
      .load_data_i  (load_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [31:0] exp_inst, input logic exp_v,
                            input logic exp_e);
      check_eq({tag, "_inst"}, inst, exp_inst);
      check_eq({tag, "_valid"}, {31'b0, inst_valid}, {31'b0, exp_v});
      check_eq({tag, "_err"}, {31'b0, inst_err}, {31'b0, exp_e});
   endtask

   // Waits for ready, counting edges; injects an ignored load at edge 1000 if asked.
   task automatic wait_ready(input string tag, input bit try_load);
      int n;
      int quiet_bad;
      n = 0;
      quiet_bad = 0;
      while (!ready && n < 2000) begin
         if (try_load && n == 1000) begin
            load_we   = 1'b1;
            load_addr = 10'd3;
            load_data = 32'hDEAD_BEEF;
         end else begin
            load_we = 1'b0;
         end
         tick();
         n++;
         if (!ready && (inst !== 32'h0 || inst_valid !== 1'b0 || inst_err !== 1'b0)) begin
            quiet_bad++;
         end
      end
      load_we = 1'b0;
      check_eq({tag, "_init_cycles"}, n, 1024);
      check_eq({tag, "_init_quiet"}, quiet_bad, 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      ce        = 1'b0;
      pc        = 32'h0;
      load_we   = 1'b0;
      load_addr = '0;
      load_data = '0;
      repeat (3) tick();
      check_out("rst", 32'h0, 1'b0, 1'b0);
      check_eq("rst_ready", {31'b0, ready}, 32'h0);

      rst_n = 1'b1;
      wait_ready("boot", 1'b0);
      check_eq("boot_ready", {31'b0, ready}, 32'h1);

      // Load then fetch.
      load_we = 1'b1; load_addr = 10'd0; load_data = 32'h3401_1100;
      tick();
      load_addr = 10'd1; load_data = 32'h3402_0020;
      tick();
      load_we = 1'b0;
      ce = 1'b1; pc = 32'h0;
      tick();
      check_out("fetch0", 32'h3401_1100, 1'b1, 1'b0);
      pc = 32'h4;
      tick();
      check_out("fetch1", 32'h3402_0020, 1'b1, 1'b0);
      ce = 1'b0;
      tick();
      check_out("idle", 32'h0, 1'b0, 1'b0);

      // Sequential stream of 16 preloaded words.
      for (int i = 0; i < 16; i++) begin
         load_we   = 1'b1;
         load_addr = 10'(i);
         load_data = 32'hC0DE_0000 + 32'(i * 17);
         tick();
      end
      load_we = 1'b0;
      ce = 1'b1;
      for (int i = 0; i < 16; i++) begin
         pc = 32'(i * 4);
         tick();
         check_eq($sformatf("stream%0d", i), inst, 32'hC0DE_0000 + 32'(i * 17));
         check_eq($sformatf("stream%0d_v", i), {31'b0, inst_valid}, 32'h1);
      end

      // Error qualification.
      pc = 32'h0000_0002;
      tick();
      check_out("misalign", 32'h0, 1'b1, 1'b1);
      pc = 32'h0000_1000;
      tick();
      check_out("oor", 32'h0, 1'b1, 1'b1);
      pc = 32'h8000_0000;
      tick();
      check_out("oor_hi", 32'h0, 1'b1, 1'b1);

      // Read-before-write collision on word 5.
      ce = 1'b0;
      load_we = 1'b1; load_addr = 10'd5; load_data = 32'h5555_5555;
      tick();
      ce = 1'b1; pc = 32'h14;
      load_data = 32'hAAAA_AAAA;
      tick();
      check_out("coll_old", 32'h5555_5555, 1'b1, 1'b0);
      load_we = 1'b0;
      tick();
      check_out("coll_new", 32'hAAAA_AAAA, 1'b1, 1'b0);

      // Mid-run asynchronous reset while streaming.
      pc = 32'h0;
      tick();
      check_out("pre_rst", 32'hC0DE_0000, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_out("async_rst", 32'h0, 1'b0, 1'b0);
      check_eq("async_rst_ready", {31'b0, ready}, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      wait_ready("rerun", 1'b1);
      pc = 32'h0;
      tick();
      check_out("cleared0", 32'h0, 1'b1, 1'b0);
      pc = 32'hC;
      tick();
      check_out("init_load_ignored", 32'h0, 1'b1, 1'b0);
      ce = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
